// File: rtl/spm_banked_xbar_if.sv
// LSU-side request/response bus of the banked scratchpad crossbar.
// Address, write data and read data are flattened, one slice per port.
interface spm_banked_xbar_if #(
  parameter int N_PORT = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [N_PORT-1:0]        req_valid;
  logic [N_PORT-1:0]        req_we;
  logic [N_PORT*ADDR_W-1:0] req_addr;
  logic [N_PORT*DATA_W-1:0] req_wdata;
  logic [N_PORT-1:0]        req_ready;
  logic [N_PORT-1:0]        rsp_valid;
  logic [N_PORT*DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spm_banked_xbar.sv
// N_PORT x N_BANK word-interleaved scratchpad crossbar with per-bank round-robin
// arbitration, one-cycle read responses and an external preload port.
module spm_banked_xbar #(
  parameter int N_PORT = 4,
  parameter int N_BANK = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              run,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  spm_banked_xbar_if.slave  lsu,
  output logic [CNT_W-1:0]  conflict_cnt
);
  localparam int BANK_W = $clog2(N_BANK);
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int DEPTH  = 1 << ROW_W;
  localparam int PORT_W = $clog2(N_PORT);

  logic [DATA_W-1:0] mem [N_BANK][DEPTH];
  logic [PORT_W-1:0] rr_ptr [N_BANK];

  logic [BANK_W-1:0] port_bank [N_PORT];
  logic [ROW_W-1:0]  port_row  [N_PORT];
  logic [N_BANK-1:0] gnt_vld;
  logic [PORT_W-1:0] gnt_port [N_BANK];
  logic [N_PORT-1:0] accept;
  logic              active;

  logic [N_BANK-1:0] bank_we;
  logic [N_BANK-1:0] bank_re;
  logic [ROW_W-1:0]  bank_row   [N_BANK];
  logic [DATA_W-1:0] bank_wdata [N_BANK];
  logic [DATA_W-1:0] bank_rdata [N_BANK];

  logic [N_PORT-1:0] rsp_vld_q;
  logic [BANK_W-1:0] rsp_tag  [N_PORT];
  logic [DATA_W-1:0] rsp_hold [N_PORT];
  logic [DATA_W-1:0] rsp_data [N_PORT];

  // rst is folded in so req_ready is forced low while reset is asserted
  assign active = rst & run & ~init;

  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      port_bank[p] = lsu.req_addr[p*ADDR_W +: BANK_W];
      port_row[p]  = lsu.req_addr[p*ADDR_W+BANK_W +: ROW_W];
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = '0;
    for (int b = 0; b < N_BANK; b++) begin
      gnt_port[b] = '0;
      for (int k = 0; k < N_PORT; k++) begin
        idx = int'(rr_ptr[b]) + k;
        if (idx >= N_PORT) idx = idx - N_PORT;
        if (!gnt_vld[b] && active && lsu.req_valid[idx] && int'(port_bank[idx]) == b) begin
          gnt_vld[b]  = 1'b1;
          gnt_port[b] = PORT_W'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      accept[p] = gnt_vld[port_bank[p]] && (gnt_port[port_bank[p]] == PORT_W'(p));
    end
  end

  assign lsu.req_ready = accept;

  // Per-bank SRAM port: the ext preload owns every bank in init mode
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      bank_we[b]    = 1'b0;
      bank_re[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      if (rst && init) begin
        if (ext_we && int'(ext_addr[BANK_W-1:0]) == b) begin
          bank_we[b]    = 1'b1;
          bank_row[b]   = ext_addr[ADDR_W-1:BANK_W];
          bank_wdata[b] = ext_wdata;
        end
      end else if (gnt_vld[b]) begin
        bank_row[b]   = port_row[gnt_port[b]];
        bank_we[b]    = lsu.req_we[gnt_port[b]];
        bank_re[b]    = ~lsu.req_we[gnt_port[b]];
        bank_wdata[b] = lsu.req_wdata[int'(gnt_port[b])*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++) begin
      if (bank_we[b]) mem[b][bank_row[b]] <= bank_wdata[b];
      if (bank_re[b]) bank_rdata[b] <= mem[b][bank_row[b]];
    end
  end

  // Bank output is valid only in the response cycle; otherwise replay the held word
  always_comb begin
    lsu.rsp_rdata = '0;
    for (int p = 0; p < N_PORT; p++) begin
      rsp_data[p] = rsp_vld_q[p] ? bank_rdata[rsp_tag[p]] : rsp_hold[p];
      lsu.rsp_rdata[p*DATA_W +: DATA_W] = rsp_data[p];
    end
  end

  assign lsu.rsp_valid = rsp_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_vld_q    <= '0;
      conflict_cnt <= '0;
      for (int b = 0; b < N_BANK; b++) rr_ptr[b] <= '0;
      for (int p = 0; p < N_PORT; p++) begin
        rsp_tag[p]  <= '0;
        rsp_hold[p] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        if (gnt_vld[b]) begin
          rr_ptr[b] <= (gnt_port[b] == PORT_W'(N_PORT-1)) ? '0 : gnt_port[b] + 1'b1;
        end
      end
      for (int p = 0; p < N_PORT; p++) begin
        rsp_vld_q[p] <= accept[p] & ~lsu.req_we[p];
        rsp_hold[p]  <= rsp_data[p];
        if (accept[p]) rsp_tag[p] <= port_bank[p];
      end
      if (active && |(lsu.req_valid & ~accept) && conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spm_banked_xbar.sv
// Directed bench for spm_banked_xbar: reference memory plus a response scoreboard.
module tb_spm_banked_xbar;
  localparam int N_PORT = 4;
  localparam int N_BANK = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              init = 1'b0;
  logic              run = 1'b0;
  logic              ext_we = 1'b0;
  logic [ADDR_W-1:0] ext_addr = '0;
  logic [DATA_W-1:0] ext_wdata = '0;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;
  logic auto_drop = 1'b1;
  logic [DATA_W-1:0] ref_mem [1<<ADDR_W];

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  spm_banked_xbar_if #(.N_PORT(N_PORT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) lsu();

  spm_banked_xbar #(
    .N_PORT(N_PORT), .N_BANK(N_BANK), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .run(run),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .lsu(lsu), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input int addr,
                       input logic [DATA_W-1:0] wd);
    lsu.req_valid[p] = v;
    lsu.req_we[p]    = we;
    lsu.req_addr[p*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    lsu.req_wdata[p*DATA_W +: DATA_W] = wd;
  endtask

  function automatic logic [DATA_W-1:0] rdata(input int p);
    return lsu.rsp_rdata[p*DATA_W +: DATA_W];
  endfunction

  // One clock: check grants, push expected reads, update reference memory, check responses
  task automatic step(input logic [N_PORT-1:0] exp_rdy, input string tag);
    logic [N_PORT-1:0] acc;
    logic [N_PORT-1:0] exp_v;
    rsp_t e;
    int a;
    @(negedge clk);
    chk({tag, "/ready"}, 64'(lsu.req_ready), 64'(exp_rdy));
    acc = lsu.req_valid & exp_rdy;
    for (int p = 0; p < N_PORT; p++) begin
      if (acc[p] && !lsu.req_we[p]) begin
        a = int'(lsu.req_addr[p*ADDR_W +: ADDR_W]);
        e.port = p;
        e.data = ref_mem[a];
        sb.push_back(e);
      end
    end
    for (int p = 0; p < N_PORT; p++) begin
      if (acc[p] && lsu.req_we[p]) begin
        a = int'(lsu.req_addr[p*ADDR_W +: ADDR_W]);
        ref_mem[a] = lsu.req_wdata[p*DATA_W +: DATA_W];
      end
    end
    if (init && ext_we) ref_mem[int'(ext_addr)] = ext_wdata;
    @(posedge clk);
    #1;
    exp_v = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_v[e.port] = 1'b1;
      chk({tag, "/rdata"}, 64'(rdata(e.port)), 64'(e.data));
    end
    chk({tag, "/rsp_valid"}, 64'(lsu.rsp_valid), 64'(exp_v));
    if (auto_drop) lsu.req_valid = lsu.req_valid & ~acc;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    lsu.req_valid = '0;
    lsu.req_we    = '0;
    lsu.req_addr  = '0;
    lsu.req_wdata = '0;
    for (int i = 0; i < (1<<ADDR_W); i++) ref_mem[i] = '0;

    // Reset with a pending request: nothing may be granted
    run = 1'b1;
    drive(0, 1'b1, 1'b0, 5, '0);
    #12;
    chk("rst/ready", 64'(lsu.req_ready), 64'(0));
    chk("rst/rsp_valid", 64'(lsu.rsp_valid), 64'(0));
    chk("rst/rsp_rdata", 64'(lsu.rsp_rdata[63:0]), 64'(0));
    chk("rst/cnt", 64'(conflict_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    lsu.req_valid = '0;
    run = 1'b0;
    @(posedge clk);
    #1;

    // Preload addr k = 3*k
    init = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ext_we = 1'b1;
      ext_addr = ADDR_W'(k);
      ext_wdata = DATA_W'(3*k);
      step('0, "preload");
    end
    ext_we = 1'b0;
    init = 1'b0;
    run = 1'b1;

    drive(0, 1'b1, 1'b0, 5, '0);
    step(4'b0001, "single");
    chk("single/data15", 64'(rdata(0)), 64'(15));
    step('0, "single_idle");
    chk("single/hold", 64'(rdata(0)), 64'(15));

    // Neither init nor run: no grants, no stall counting
    run = 1'b0;
    drive(1, 1'b1, 1'b0, 2, '0);
    step('0, "idle_mode");
    lsu.req_valid = '0;
    run = 1'b1;

    for (int p = 0; p < N_PORT; p++) drive(p, 1'b1, 1'b0, p, '0);
    step(4'b1111, "parallel");
    chk("parallel/cnt", 64'(conflict_cnt), 64'(0));

    // Reset in the cycle after an accepted read
    drive(0, 1'b1, 1'b0, 2, '0);
    @(negedge clk);
    chk("rstc/ready", 64'(lsu.req_ready), 64'(1));
    @(posedge clk);
    #1;
    chk("rstc/pre_valid", 64'(lsu.rsp_valid), 64'(1));
    chk("rstc/pre_data", 64'(rdata(0)), 64'(6));
    lsu.req_valid = '0;
    #2;
    rst = 1'b0;
    #1;
    chk("rstc/valid", 64'(lsu.rsp_valid), 64'(0));
    chk("rstc/data", 64'(rdata(0)), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstc/post_valid", 64'(lsu.rsp_valid), 64'(0));
    step('0, "rstc_idle");
    chk("rstc/cnt", 64'(conflict_cnt), 64'(0));

    // Full conflict on bank 0
    for (int p = 0; p < N_PORT; p++) drive(p, 1'b1, 1'b0, 4*p, '0);
    step(4'b0001, "conflict0");
    step(4'b0010, "conflict1");
    step(4'b0100, "conflict2");
    step(4'b1000, "conflict3");
    chk("conflict/data36", 64'(rdata(3)), 64'(36));
    chk("conflict/cnt", 64'(conflict_cnt), 64'(3));

    // Round-robin fairness on bank 1
    auto_drop = 1'b0;
    drive(0, 1'b1, 1'b0, 1, '0);
    drive(1, 1'b1, 1'b0, 5, '0);
    for (int i = 0; i < 6; i++) step((i % 2 == 1) ? 4'b0010 : 4'b0001, "rr");
    auto_drop = 1'b1;
    lsu.req_valid = '0;
    chk("rr/cnt", 64'(conflict_cnt), 64'(9));

    // Read-after-write across ports
    drive(2, 1'b1, 1'b1, 7, 32'hDEADBEEF);
    step(4'b0100, "raw_wr");
    drive(3, 1'b1, 1'b0, 7, '0);
    step(4'b1000, "raw_rd");
    chk("raw/data", 64'(rdata(3)), 64'(32'hDEADBEEF));

    // init wins over run
    init = 1'b1;
    ext_we = 1'b1;
    ext_addr = ADDR_W'(20);
    ext_wdata = 32'hA5A5_0001;
    drive(0, 1'b1, 1'b0, 3, '0);
    step('0, "init_run");
    ext_we = 1'b0;
    init = 1'b0;
    lsu.req_valid = '0;
    drive(1, 1'b1, 1'b0, 20, '0);
    step(4'b0010, "init_run_rd");
    chk("init_run/data", 64'(rdata(1)), 64'(32'hA5A5_0001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spm_banked_xbar.md
Name: spm_banked_xbar

Overview:
- Parametrised successor to the fixed 4x4 crossbar plus scratchpad pair: N_PORT LSU request ports reach N_BANK word-interleaved single-port SRAM banks.
- Per-bank round-robin arbitration, valid/ready request handshake, fixed-latency read responses routed back to the requesting port.
- Sits between the PE array LSUs and on-chip scratchpad storage. An external init port preloads bank contents while `init` is high.

Parameters:
- N_PORT, 4, number of LSU request/response ports (2..8).
- N_BANK, 4, number of banks; power of two (2..8).
- DATA_W, 32, data word width.
- ADDR_W, 10, word address width; bank = addr[log2(N_BANK)-1:0], row = remaining upper bits.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- init  in  1  preload mode; ext port owns all banks.
- run  in  1  execute mode; LSU ports arbitrated.
- ext_we  in  1  preload write strobe (honoured only when init=1).
- ext_addr  in  ADDR_W  preload word address.
- ext_wdata  in  DATA_W  preload data.
- req_valid  in  N_PORT  per-port request valid.
- req_we  in  N_PORT  per-port request type: 1=write, 0=read.
- req_addr  in  N_PORT*ADDR_W  flattened; port p at [p*ADDR_W +: ADDR_W].
- req_wdata  in  N_PORT*DATA_W  flattened write data.
- req_ready  out  N_PORT  combinational grant; request accepted when valid & ready.
- rsp_valid  out  N_PORT  registered read-response valid.
- rsp_rdata  out  N_PORT*DATA_W  flattened read data.
- conflict_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=0, async):
  - rsp_valid=0, rsp_rdata=0, conflict_cnt=0, all RR pointers=0.
  - req_ready forced 0.
  - SRAM contents not reset.
  - In-flight read responses are discarded; nothing is emitted after reset releases.
- Mode priority: init over run.
  - init=1: req_ready=0; ext_we writes bank[ext_addr] that cycle.
  - init=0, run=0: req_ready=0, no memory access.
  - run=1 (init=0): arbitration active.
- Arbitration, per bank b, each cycle:
  - Candidates = ports with req_valid=1 whose bank field equals b.
  - Grant the first candidate at or after ptr[b], searching upward with wrap at N_PORT.
  - On a grant, ptr[b] <= granted+1 (mod N_PORT). Without a grant, ptr[b] holds.
  - At most one grant per bank per cycle. Each port targets one bank, so a port gets at most one grant.
  - Ports hitting different banks are granted in the same cycle.
- Write accept: the bank row is written at the clock edge. No response is produced.
- Read accept:
  - Synchronous bank read; rsp_valid[p]=1 for exactly 1 cycle, 1 cycle after acceptance.
  - Routing tag (bank id) is registered alongside.
  - Back-to-back accepted reads give back-to-back responses; sustained throughput is 1 read/port/cycle.
- rsp_rdata[p] holds its last value while rsp_valid[p]=0.
- Read-after-write, same address, consecutive cycles: the read returns the new data.
- Unaccepted requests: requester holds valid/addr/data stable; the block keeps no request state.
- conflict_cnt: +1 on each run cycle in which any port has valid & !ready. Saturates at all-ones.
- Mode change mid-stream: a read accepted in the last run cycle still produces its response in the next cycle.

Test Plan:
- Preload, then single read: init=1, ext writes addr k = 3*k for k=0..15; init=0, run=1; port0 reads addr 5 -> req_ready[0]=1 same cycle, rsp_valid[0]=1 next cycle with rsp_rdata=15.
- Parallel, no conflict: ports 0..3 read addrs 0,1,2,3 in one cycle -> all ready=1; next cycle all rsp_valid=1, data 0,3,6,9; conflict_cnt stays 0.
- Full bank conflict: ports 0..3 hold reads of addrs 0,4,8,12 (all bank 0) -> grants to ports 0,1,2,3 on consecutive cycles; responses 0,12,24,36; conflict_cnt=3.
- RR fairness: ports 0 and 1 continuously read bank 1 for 6 cycles -> grants alternate 0,1,0,1,0,1.
- RAW: port2 writes 0xDEADBEEF to addr 7 at t; port3 reads addr 7 at t+1 -> rsp_valid[3] at t+2, data 0xDEADBEEF.
- Reset/mode corner:
  - rst=0 in the cycle after a read is accepted -> rsp_valid stays 0 after release, conflict_cnt=0.
  - init=1 and run=1 together -> req_ready=0 and ext writes land.
